// File: rtl/hazard_fwd_ctrl.sv
// Forwarding and hazard controller for a 5-stage RISC-V pipeline.
// Selects EX operand sources (MEM / WB / register file) per source operand,
// sequences load-use stalls of configurable depth, and tracks a single
// outstanding multi-cycle (mul/div) operation in a one-entry scoreboard.
module hazard_fwd_ctrl #(
  parameter int AW       = 5,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1,
  parameter int MD_LAT   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_SRC*AW-1:0] id_rs,
  input  logic [NUM_SRC-1:0]    id_rs_used,
  input  logic                  id_md,
  input  logic [NUM_SRC*AW-1:0] ex_rs,
  input  logic [AW-1:0]         ex_rd,
  input  logic                  ex_RegWEn,
  input  logic                  ex_MemRead,
  input  logic                  ex_md_start,
  input  logic [AW-1:0]         mem_rd,
  input  logic                  mem_RegWEn,
  input  logic                  mem_MemRead,
  input  logic [AW-1:0]         wb_rd,
  input  logic                  wb_RegWEn,
  output logic [2*NUM_SRC-1:0]  fw_sel,
  output logic                  stall_if,
  output logic                  stall_id,
  output logic                  flush_ex,
  output logic                  md_busy,
  output logic                  md_wb_req,
  output logic [AW-1:0]         md_rd
);

  typedef enum logic {RUN = 1'b0, LD_STALL = 1'b1} state_t;

  // The first stall cycle is spent in RUN, so the counter covers the rest.
  localparam logic [2:0] LD_INIT = (LOAD_LAT > 1) ? 3'(LOAD_LAT - 2) : 3'd0;
  localparam logic [3:0] MD_INIT = 4'(MD_LAT - 1);

  state_t     state, state_nxt;
  logic [2:0] ld_cnt, ld_cnt_nxt;
  logic [3:0] md_cnt;
  logic       load_use;
  logic       md_haz;
  logic       stall;

  // Per-source operand forwarding; MEM wins over WB, x0 never forwards,
  // and a load in MEM has no data yet so it cannot forward.
  always_comb begin
    fw_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (mem_RegWEn && !mem_MemRead && (mem_rd != '0) &&
          (mem_rd == ex_rs[i*AW +: AW]))
        fw_sel[2*i +: 2] = 2'b10;
      else if (wb_RegWEn && (wb_rd != '0) && (wb_rd == ex_rs[i*AW +: AW]))
        fw_sel[2*i +: 2] = 2'b01;
    end
  end

  // Load-use and multi-cycle dependency detection against the ID operands.
  always_comb begin
    logic ld_hit;
    logic md_hit;
    ld_hit = 1'b0;
    md_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_rs_used[i] && (id_rs[i*AW +: AW] == ex_rd)) ld_hit = 1'b1;
      if (id_rs_used[i] && (id_rs[i*AW +: AW] == md_rd)) md_hit = 1'b1;
    end
    load_use = ex_MemRead && ex_RegWEn && (ex_rd != '0) && ld_hit;
    md_haz   = md_busy && (id_md || (md_hit && (md_rd != '0)));
  end

  // Load-stall sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      ld_cnt <= 3'd0;
    end else begin
      state  <= state_nxt;
      ld_cnt <= ld_cnt_nxt;
    end
  end

  // Load-stall sequencer next state; LD_STALL runs regardless of md stalls.
  always_comb begin
    state_nxt  = state;
    ld_cnt_nxt = ld_cnt;
    case (state)
      RUN: begin
        if (load_use && (LOAD_LAT > 1)) begin
          state_nxt  = LD_STALL;
          ld_cnt_nxt = LD_INIT;
        end
      end
      LD_STALL: begin
        if (ld_cnt == 3'd0) state_nxt  = RUN;
        else                ld_cnt_nxt = ld_cnt - 3'd1;
      end
      default: state_nxt = RUN;
    endcase
  end

  // Pipeline hold/bubble outputs; forced low while reset is asserted.
  always_comb begin
    stall = rst_n && ((state == LD_STALL) ||
                      ((state == RUN) && load_use) ||
                      md_haz);
    stall_if = stall;
    stall_id = stall;
    flush_ex = stall;
  end

  // Single-entry scoreboard; a start while busy is ignored unless it lands
  // on the result cycle, in which case the new op is accepted back-to-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_busy <= 1'b0;
      md_cnt  <= 4'd0;
      md_rd   <= '0;
    end else if (ex_md_start && (!md_busy || md_wb_req)) begin
      md_busy <= 1'b1;
      md_cnt  <= MD_INIT;
      md_rd   <= ex_rd;
    end else if (md_busy) begin
      if (md_cnt == 4'd0) md_busy <= 1'b0;
      else                md_cnt  <= md_cnt - 4'd1;
    end
  end

  assign md_wb_req = md_busy && (md_cnt == 4'd0);

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed testbench for hazard_fwd_ctrl: one instance with LOAD_LAT=1 and
// one with LOAD_LAT=3 share the same stimulus.
module tb_hazard_fwd_ctrl;

  localparam int AW = 5;
  localparam int NS = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NS*AW-1:0] id_rs, ex_rs;
  logic [NS-1:0] id_rs_used;
  logic          id_md, ex_RegWEn, ex_MemRead, ex_md_start;
  logic [AW-1:0] ex_rd, mem_rd, wb_rd;
  logic          mem_RegWEn, mem_MemRead, wb_RegWEn;

  logic [2*NS-1:0] o1_fw_sel, o3_fw_sel;
  logic o1_stall_if, o1_stall_id, o1_flush_ex, o1_md_busy, o1_md_wb_req;
  logic o3_stall_if, o3_stall_id, o3_flush_ex, o3_md_busy, o3_md_wb_req;
  logic [AW-1:0] o1_md_rd, o3_md_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_fwd_ctrl #(.AW(AW), .NUM_SRC(NS), .LOAD_LAT(1), .MD_LAT(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_md(id_md), .ex_rs(ex_rs), .ex_rd(ex_rd), .ex_RegWEn(ex_RegWEn),
    .ex_MemRead(ex_MemRead), .ex_md_start(ex_md_start), .mem_rd(mem_rd),
    .mem_RegWEn(mem_RegWEn), .mem_MemRead(mem_MemRead), .wb_rd(wb_rd),
    .wb_RegWEn(wb_RegWEn), .fw_sel(o1_fw_sel), .stall_if(o1_stall_if),
    .stall_id(o1_stall_id), .flush_ex(o1_flush_ex), .md_busy(o1_md_busy),
    .md_wb_req(o1_md_wb_req), .md_rd(o1_md_rd));

  hazard_fwd_ctrl #(.AW(AW), .NUM_SRC(NS), .LOAD_LAT(3), .MD_LAT(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_md(id_md), .ex_rs(ex_rs), .ex_rd(ex_rd), .ex_RegWEn(ex_RegWEn),
    .ex_MemRead(ex_MemRead), .ex_md_start(ex_md_start), .mem_rd(mem_rd),
    .mem_RegWEn(mem_RegWEn), .mem_MemRead(mem_MemRead), .wb_rd(wb_rd),
    .wb_RegWEn(wb_RegWEn), .fw_sel(o3_fw_sel), .stall_if(o3_stall_if),
    .stall_id(o3_stall_id), .flush_ex(o3_flush_ex), .md_busy(o3_md_busy),
    .md_wb_req(o3_md_wb_req), .md_rd(o3_md_rd));

  task automatic clear_inputs();
    id_rs = '0; ex_rs = '0; id_rs_used = '0; id_md = 1'b0;
    ex_rd = '0; ex_RegWEn = 1'b0; ex_MemRead = 1'b0; ex_md_start = 1'b0;
    mem_rd = '0; mem_RegWEn = 1'b0; mem_MemRead = 1'b0;
    wb_rd = '0; wb_RegWEn = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    // load-use pattern present during reset must not stall
    ex_rd = 5'd7; ex_MemRead = 1'b1; ex_RegWEn = 1'b1;
    id_rs = {5'd0, 5'd7}; id_rs_used = 2'b01;
    #2;
    checks++;
    if ({o1_stall_if, o1_stall_id, o1_flush_ex, o3_stall_if, o3_stall_id, o3_flush_ex} !== 6'b0) begin
      errors++; $display("FAIL reset_stall got %b exp 000000",
        {o1_stall_if, o1_stall_id, o1_flush_ex, o3_stall_if, o3_stall_id, o3_flush_ex});
    end
    checks++;
    if ({o1_md_busy, o1_md_wb_req, o3_md_busy, o3_md_wb_req} !== 4'b0) begin
      errors++; $display("FAIL reset_md got %b exp 0000",
        {o1_md_busy, o1_md_wb_req, o3_md_busy, o3_md_wb_req});
    end
    checks++;
    if (o1_md_rd !== 5'd0 || o3_md_rd !== 5'd0) begin
      errors++; $display("FAIL reset_md_rd got %0d/%0d exp 0", o1_md_rd, o3_md_rd);
    end
    clear_inputs();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_forward();
    clear_inputs();
    ex_rs = {5'd0, 5'd5}; mem_rd = 5'd5; mem_RegWEn = 1'b1;
    wb_rd = 5'd5; wb_RegWEn = 1'b1;
    #1;
    checks++;
    if (o1_fw_sel !== 4'b0010) begin
      errors++; $display("FAIL fw_mem_prio got %b exp 0010", o1_fw_sel);
    end
    mem_RegWEn = 1'b0;
    #1;
    checks++;
    if (o1_fw_sel !== 4'b0001) begin
      errors++; $display("FAIL fw_wb got %b exp 0001", o1_fw_sel);
    end
    ex_rs = '0; mem_rd = 5'd0; mem_RegWEn = 1'b1; wb_rd = 5'd0;
    #1;
    checks++;
    if (o1_fw_sel !== 4'b0000) begin
      errors++; $display("FAIL fw_x0 got %b exp 0000", o1_fw_sel);
    end
    // a load in MEM must not forward; WB takes over for src1
    ex_rs = {5'd9, 5'd3}; mem_rd = 5'd9; mem_RegWEn = 1'b1; mem_MemRead = 1'b1;
    wb_rd = 5'd9; wb_RegWEn = 1'b1;
    #1;
    checks++;
    if (o1_fw_sel !== 4'b0100) begin
      errors++; $display("FAIL fw_mem_load got %b exp 0100", o1_fw_sel);
    end
    // src0 from MEM, src1 from WB at once
    ex_rs = {5'd9, 5'd5}; mem_rd = 5'd5; mem_MemRead = 1'b0;
    #1;
    checks++;
    if (o3_fw_sel !== 4'b0110) begin
      errors++; $display("FAIL fw_mixed got %b exp 0110", o3_fw_sel);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_load_use();
    int  n3;
    logic e1, e3;
    n3 = 0;
    clear_inputs();
    ex_rd = 5'd7; ex_MemRead = 1'b1; ex_RegWEn = 1'b1;
    id_rs = {5'd7, 5'd0}; id_rs_used = 2'b10;
    for (int c = 0; c < 5; c++) begin
      #1;
      e1 = (c < 1);
      e3 = (c < 3);
      checks++;
      if ({o1_stall_if, o1_stall_id, o1_flush_ex} !== {3{e1}}) begin
        errors++; $display("FAIL ld_lat1_c%0d got %b exp %b", c,
          {o1_stall_if, o1_stall_id, o1_flush_ex}, {3{e1}});
      end
      checks++;
      if ({o3_stall_if, o3_stall_id, o3_flush_ex} !== {3{e3}}) begin
        errors++; $display("FAIL ld_lat3_c%0d got %b exp %b", c,
          {o3_stall_if, o3_stall_id, o3_flush_ex}, {3{e3}});
      end
      if (o3_stall_if === 1'b1) n3++;
      tick();
      if (c == 0) clear_inputs();
    end
    checks++;
    if (n3 !== 3) begin
      errors++; $display("FAIL ld_lat3_count got %0d exp 3", n3);
    end
    // operand not actually read: no hazard
    ex_rd = 5'd7; ex_MemRead = 1'b1; ex_RegWEn = 1'b1;
    id_rs = {5'd7, 5'd7}; id_rs_used = 2'b00;
    #1;
    checks++;
    if (o1_stall_if !== 1'b0 || o3_stall_if !== 1'b0) begin
      errors++; $display("FAIL ld_unused got %b%b exp 00", o1_stall_if, o3_stall_if);
    end
    // load to x0: no hazard
    ex_rd = 5'd0; id_rs = '0; id_rs_used = 2'b11;
    #1;
    checks++;
    if (o1_stall_if !== 1'b0 || o3_stall_if !== 1'b0) begin
      errors++; $display("FAIL ld_x0 got %b%b exp 00", o1_stall_if, o3_stall_if);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_md();
    logic eb, ew, es;
    clear_inputs();
    id_md = 1'b1;
    #1;
    checks++;
    if (o1_stall_if !== 1'b0) begin
      errors++; $display("FAIL md_idle_idmd got %b exp 0", o1_stall_if);
    end
    id_md = 1'b0;
    ex_md_start = 1'b1; ex_rd = 5'd12;
    #1;
    checks++;
    if (o1_md_busy !== 1'b0) begin
      errors++; $display("FAIL md_issue_busy got %b exp 0", o1_md_busy);
    end
    tick();
    clear_inputs();
    for (int k = 1; k <= 6; k++) begin
      id_rs = {5'd0, 5'd12}; id_rs_used = 2'b01;
      // a start while busy is a protocol error and must be ignored
      if (k == 2) begin ex_md_start = 1'b1; ex_rd = 5'd20; end
      else        begin ex_md_start = 1'b0; ex_rd = 5'd0;  end
      #1;
      eb = (k <= 4);
      ew = (k == 4);
      es = (k <= 4);
      checks++;
      if ({o1_md_busy, o1_md_wb_req} !== {eb, ew}) begin
        errors++; $display("FAIL md_k%0d busy/req got %b exp %b", k,
          {o1_md_busy, o1_md_wb_req}, {eb, ew});
      end
      checks++;
      if (o1_stall_if !== es || o1_flush_ex !== es) begin
        errors++; $display("FAIL md_stall_k%0d got %b%b exp %b", k,
          o1_stall_if, o1_flush_ex, es);
      end
      if (k <= 4) begin
        checks++;
        if (o1_md_rd !== 5'd12) begin
          errors++; $display("FAIL md_rd_k%0d got %0d exp 12", k, o1_md_rd);
        end
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    logic eb, ew, es;
    logic [AW-1:0] er;
    clear_inputs();
    ex_md_start = 1'b1; ex_rd = 5'd12;
    tick();
    for (int k = 1; k <= 9; k++) begin
      clear_inputs();
      id_md = (k <= 3);
      if (k == 4) begin ex_md_start = 1'b1; ex_rd = 5'd13; end
      #1;
      eb = (k <= 8);
      ew = (k == 4) || (k == 8);
      es = (k <= 3);
      er = (k <= 4) ? 5'd12 : 5'd13;
      checks++;
      if ({o1_md_busy, o1_md_wb_req} !== {eb, ew}) begin
        errors++; $display("FAIL b2b_k%0d busy/req got %b exp %b", k,
          {o1_md_busy, o1_md_wb_req}, {eb, ew});
      end
      checks++;
      if (o1_stall_id !== es) begin
        errors++; $display("FAIL b2b_stall_k%0d got %b exp %b", k, o1_stall_id, es);
      end
      if (k <= 8) begin
        checks++;
        if (o1_md_rd !== er) begin
          errors++; $display("FAIL b2b_rd_k%0d got %0d exp %0d", k, o1_md_rd, er);
        end
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    // load-use and multi-cycle issue in the same cycle
    ex_md_start = 1'b1; ex_rd = 5'd15; ex_MemRead = 1'b1; ex_RegWEn = 1'b1;
    id_rs = {5'd0, 5'd15}; id_rs_used = 2'b01;
    tick();
    clear_inputs();
    #1;
    checks++;
    if ({o3_stall_if, o3_md_busy} !== 2'b11) begin
      errors++; $display("FAIL rstmid_pre got %b exp 11", {o3_stall_if, o3_md_busy});
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o3_stall_if, o3_stall_id, o3_flush_ex, o3_md_busy, o3_md_wb_req} !== 5'b0 ||
        o3_md_rd !== 5'd0 || o3_fw_sel !== 4'b0) begin
      errors++; $display("FAIL rstmid_async got %b rd %0d exp 00000 rd 0",
        {o3_stall_if, o3_stall_id, o3_flush_ex, o3_md_busy, o3_md_wb_req}, o3_md_rd);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({o1_stall_if, o3_stall_if, o3_md_busy, o1_md_busy} !== 4'b0) begin
        errors++; $display("FAIL rstmid_after_k%0d got %b exp 0000", k,
          {o1_stall_if, o3_stall_if, o3_md_busy, o1_md_busy});
      end
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_md();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
